booth_mult_issue: RTL and testbench

Operand issue and result-return stage wrapped around booth_radix8_multiplier. Accepts tagged operand pairs on a valid/ready stream and buffers them in a small FIFO. Launches one multiplication at a time through the multiplier's start/done interface and returns each product with its tag on a valid/ready output stream. Converts the multiplier's pulse protocol into back-pressurable streams, for use by the upstream datapath and the downstream accumulator.

---
 rtl/booth_mult_issue_pkg.sv | 17 +
 rtl/booth_op_fifo.sv | 61 ++++++
 rtl/booth_mult_issue.sv | 124 ++++++++++++
 tb/tb_booth_mult_issue.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_issue_pkg.sv
// Shared definitions for the Booth multiplier issue stage.
// Used by the issue stage and the other multiplier wrappers.
package booth_mult_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Bit positions inside a sign_mode field.
    localparam int SIGN_A = 1;
    localparam int SIGN_B = 0;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous FIFO holding {sign_mode, tag, mult, mcand} operations.
// Writes while full and reads while empty are ignored.
module booth_op_fifo
    import booth_mult_issue_pkg::*;
#(
    parameter int DW    = 38,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    input  logic                   rd_en,
    output logic [DW-1:0]          rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mult_issue.sv
// Operand issue / result return stage around the radix-8 Booth multiplier.
// One operation is outstanding at a time; a watchdog breaks lost completions.
module booth_mult_issue
    import booth_mult_issue_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_mcand,
    input  logic [WIDTH-1:0]       in_mult,
    input  logic [1:0]             in_sign_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_mcand,
    output logic [WIDTH-1:0]       mul_mult,
    output logic [1:0]             mul_sign_mode,
    input  logic [2*WIDTH-1:0]     mul_product,
    input  logic                   mul_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_product,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_timeout
);

    localparam int DW = 2 + TAG_W + 2*WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    // Watchdog value in the last WAIT cycle before expiry.
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 2);

    state_t           state;
    logic             up_q;
    logic             full;
    logic             empty;
    logic             pop;
    logic             wr_en;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    rd_data;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    wd;

    assign in_ready = up_q && !full;
    assign wr_en    = in_valid && in_ready;
    assign wr_data  = {in_sign_mode, in_tag, in_mult, in_mcand};
    assign pop      = (state == ST_IDLE) && !empty
                   && (!out_valid || out_ready);

    booth_op_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            up_q          <= 1'b0;
            mul_start     <= 1'b0;
            mul_mcand     <= '0;
            mul_mult      <= '0;
            mul_sign_mode <= '0;
            tag_q         <= '0;
            wd            <= '0;
            out_valid     <= 1'b0;
            out_product   <= '0;
            out_tag       <= '0;
            err_timeout   <= 1'b0;
        end else begin
            up_q      <= 1'b1;
            mul_start <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {mul_sign_mode, tag_q,
                         mul_mult, mul_mcand} <= rd_data;
                        mul_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        out_product <= mul_product;
                        out_tag     <= tag_q;
                        out_valid   <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (wd == WD_LAST) begin
                        err_timeout <= 1'b1;
                        out_product <= '0;
                        out_tag     <= tag_q;
                        out_valid   <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_issue.sv
// Self-checking bench for booth_mult_issue with a stub multiplier.
// Expected products come from plain signed/unsigned arithmetic.
module tb_booth_mult_issue;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TW = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_mcand = '0;
    logic [W-1:0]    in_mult = '0;
    logic [1:0]      in_sign_mode = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            mul_start;
    logic [W-1:0]    mul_mcand;
    logic [W-1:0]    mul_mult;
    logic [1:0]      mul_sign_mode;
    logic [2*W-1:0]  mul_product;
    logic            mul_done;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  out_product;
    logic [TW-1:0]   out_tag;
    logic [$clog2(D):0] fifo_count;
    logic            err_timeout;

    int errors = 0;
    int checks = 0;

    booth_mult_issue #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TAG_W   (TW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mcand      (in_mcand),
        .in_mult       (in_mult),
        .in_sign_mode  (in_sign_mode),
        .in_tag        (in_tag),
        .mul_start     (mul_start),
        .mul_mcand     (mul_mcand),
        .mul_mult      (mul_mult),
        .mul_sign_mode (mul_sign_mode),
        .mul_product   (mul_product),
        .mul_done      (mul_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_product   (out_product),
        .out_tag       (out_tag),
        .fifo_count    (fifo_count),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   sm
    );
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = sm[1] ? longint'($signed(a)) : longint'(a);
        sb = sm[0] ? longint'($signed(b)) : longint'(b);
        p = 64'(sa * sb);
        return p[2*W-1:0];
    endfunction

    // Stub multiplier: random latency, optional hang, optional stray done.
    logic           hang = 1'b0;
    logic           stray = 1'b0;
    logic           stub_done = 1'b0;
    logic [2*W-1:0] stub_prod = '0;
    logic [W-1:0]   la = '0;
    logic [W-1:0]   lb = '0;
    logic [1:0]     lsm = '0;
    int             pend = 0;
    int             stable_viol = 0;

    assign mul_done    = stub_done | stray;
    assign mul_product = stray ? 32'hDEAD_BEEF : stub_prod;

    always @(negedge clk) begin
        stub_done = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (mul_start) begin
            la   = mul_mcand;
            lb   = mul_mult;
            lsm  = mul_sign_mode;
            pend = $urandom_range(1, 5);
        end else if (pend > 0) begin
            if (mul_mcand != la || mul_mult != lb
                || mul_sign_mode != lsm) begin
                stable_viol++;
            end
            pend--;
            if (pend == 0 && !hang) begin
                stub_done = 1'b1;
                stub_prod = ref_mul(la, lb, lsm);
            end
        end
    end

    int starts = 0;
    int max_cnt = 0;
    int full_viol = 0;

    always @(posedge clk) begin
        if (mul_start) starts++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (int'(fifo_count) == D && in_ready) full_viol++;
    end

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  tag;
    } exp_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [1:0]     sm;
        logic [TW-1:0]  tag;
        logic [2*W-1:0] p;
    } vec_t;

    exp_t q[$];

    task automatic check(
        input string       name,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(
        input logic [W-1:0]  a,
        input logic [W-1:0]  b,
        input logic [1:0]    sm,
        input logic [TW-1:0] tag
    );
        int n = 0;
        in_valid     = 1'b1;
        in_mcand     = a;
        in_mult      = b;
        in_sign_mode = sm;
        in_tag       = tag;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", {63'b0, in_ready}, 64'd1);
        if (in_ready) begin
            q.push_back('{p: ref_mul(a, b, sm), tag: tag});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic cmp_head(input string name);
        exp_t e;
        if (q.size() == 0) begin
            check({name, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            check({name, "_prod"}, 64'(out_product), 64'(e.p));
            check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
        end
    endtask

    task automatic pop_check(input string name);
        int n = 0;
        while (!(out_valid && out_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {63'b0, out_valid}, 64'd1);
        if (out_valid) cmp_head(name);
        @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        check({name, "_in_ready"}, {63'b0, in_ready}, 64'd0);
        check({name, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        check({name, "_count"}, 64'(fifo_count), 64'd0);
        check({name, "_start"}, {63'b0, mul_start}, 64'd0);
        check({name, "_err"}, {63'b0, err_timeout}, 64'd0);
        check({name, "_mcand"}, 64'(mul_mcand), 64'd0);
        check({name, "_prod"}, 64'(out_product), 64'd0);
        check({name, "_tag"}, 64'(out_tag), 64'd0);
    endtask

    vec_t vecs[7];
    int   s0;
    int   got;
    int   n;
    int   k;

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 2'b00, 4'd1, 32'h0000_000F};
        vecs[1] = '{16'hFFFD, 16'h0005, 2'b11, 4'd2, 32'hFFFF_FFF1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 2'b00, 4'd3, 32'hFFFE_0001};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 2'b11, 4'd4, 32'h0000_0001};
        vecs[4] = '{16'h8000, 16'hFFFF, 2'b10, 4'd5, 32'h8000_8000};
        vecs[5] = '{16'hFFFF, 16'h8000, 2'b01, 4'd6, 32'h8000_8000};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 2'b11, 4'd7, 32'h3FFF_0001};

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {63'b0, in_ready}, 64'd1);

        // Directed vectors with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s0 = starts;
            push(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].tag);
            q[q.size()-1].p = vecs[i].p;
            if (i == 0) begin
                check("lat_t1_start", {63'b0, mul_start}, 64'd0);
                @(negedge clk);
                check("lat_t2_start", {63'b0, mul_start}, 64'd1);
            end
            pop_check($sformatf("vec%0d", i));
            check($sformatf("vec%0d_starts", i),
                  64'(starts - s0), 64'd1);
        end

        // Back-to-back with a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(16'($urandom), 16'($urandom), 2'($urandom), 4'(i));
        end
        repeat (20) @(negedge clk);
        check("b2b_held", {63'b0, out_valid}, 64'd1);
        check("b2b_head_tag", 64'(out_tag), 64'd0);
        check("b2b_count", 64'(fifo_count), 64'(D));
        check("b2b_in_ready", {63'b0, in_ready}, 64'd0);
        fork
            push(16'($urandom), 16'($urandom), 2'($urandom), 4'd5);
            begin
                out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    pop_check($sformatf("b2b%0d", i));
                end
            end
        join

        // Random traffic with a randomly stalling consumer.
        fork
            for (int i = 0; i < 40; i++) begin
                push(16'($urandom), 16'($urandom),
                     2'($urandom), 4'($urandom));
            end
            begin
                got = 0;
                n = 0;
                while (got < 40 && n < 4000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        cmp_head("rand");
                        got++;
                    end
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("rand_count", 64'(got), 64'd40);
        check("max_count", {63'b0, max_cnt <= D}, 64'd1);
        check("full_write_ready", 64'(full_viol), 64'd0);
        check("operand_stable", 64'(stable_viol), 64'd0);

        // Watchdog: the multiplier never answers.
        out_ready = 1'b0;
        hang = 1'b1;
        push(16'h1234, 16'h5678, 2'b00, 4'd7);
        q[q.size()-1].p = '0;
        n = 0;
        while (!mul_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_start_seen", {63'b0, mul_start}, 64'd1);
        k = 0;
        while (!err_timeout && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("to_cycles", 64'(k), 64'(TO));
        check("to_out_valid", {63'b0, out_valid}, 64'd1);
        check("to_out_prod", 64'(out_product), 64'd0);
        hang = 1'b0;
        push(16'h0002, 16'h0003, 2'b00, 4'd8);
        out_ready = 1'b1;
        pop_check("to_res");
        pop_check("after_to");
        check("err_sticky", {63'b0, err_timeout}, 64'd1);

        // Reset while waiting with three queued operations.
        out_ready = 1'b0;
        hang = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(16'($urandom), 16'($urandom), 2'b00, 4'(9 + i));
        end
        repeat (2) @(negedge clk);
        check("mid_count", 64'(fifo_count), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        q.delete();
        hang = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_no_valid", {63'b0, out_valid}, 64'd0);
        check("stray_count", 64'(fifo_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
